// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-4 stream demultiplexer.
// The optional per-output transfer counters are enabled by DEMUX_STATS_EN.
package demux_pkg;

    localparam int N_OUT       = 4;
    localparam int DEF_WIDTH   = 4;
    localparam int DEF_COUNT_W = 8;

    typedef logic [1:0] sel_t;

endpackage

// File: rtl/demux_out_slot.sv
// One-entry output holding register for a single demux channel.
// Latency: load -> out_valid 1 cycle; backpressure: free = empty or draining this cycle.
// DEMUX_STATS_EN adds a wrapping transfer counter (out_cnt).
module demux_out_slot #(
    parameter int WIDTH   = 4,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_data,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic               free
`ifdef DEMUX_STATS_EN
    ,
    output logic [COUNT_W-1:0] out_cnt
`endif
);

    // A full slot is still free when its consumer takes the word this cycle,
    // which gives back-to-back throughput on a single output.
    assign free = !out_valid || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef DEMUX_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_cnt <= '0;
        end else if (out_valid && out_ready) begin
            out_cnt <= out_cnt + 1'b1;
        end
    end
`else
    logic unused_count_w;
    assign unused_count_w = ^COUNT_W;
`endif

endmodule

// File: rtl/demux_1_4_stream.sv
// Registered 1-to-4 valid/ready stream demultiplexer, routed by per-word in_sel.
// Latency: 1 cycle input handshake -> out_valid; backpressure: in_ready follows the selected slot only.
// DEMUX_STATS_EN adds per-output transfer counters out_cnt0..out_cnt3.
module demux_1_4_stream
    import demux_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int COUNT_W = DEF_COUNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   in_data,
    input  sel_t               in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   out_data0,
    output logic [WIDTH-1:0]   out_data1,
    output logic [WIDTH-1:0]   out_data2,
    output logic [WIDTH-1:0]   out_data3,
    output logic [N_OUT-1:0]   out_valid,
    input  logic [N_OUT-1:0]   out_ready
`ifdef DEMUX_STATS_EN
    ,
    output logic [COUNT_W-1:0] out_cnt0,
    output logic [COUNT_W-1:0] out_cnt1,
    output logic [COUNT_W-1:0] out_cnt2,
    output logic [COUNT_W-1:0] out_cnt3
`endif
);

    logic [N_OUT-1:0] load_vec;
    logic [N_OUT-1:0] free_vec;
    logic [N_OUT-1:0] valid_vec;
    logic [WIDTH-1:0] data_arr [N_OUT];
`ifdef DEMUX_STATS_EN
    logic [COUNT_W-1:0] cnt_arr [N_OUT];
`endif

    // Combinational through-path from out_ready of the selected channel;
    // a stall on one output never blocks words heading elsewhere.
    assign in_ready = !rst && free_vec[in_sel];

    always_comb begin
        load_vec = '0;
        if (in_valid && in_ready) begin
            load_vec[in_sel] = 1'b1;
        end
    end

    for (genvar i = 0; i < N_OUT; i++) begin : g_slot
        demux_out_slot #(
            .WIDTH   (WIDTH),
            .COUNT_W (COUNT_W)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .load      (load_vec[i]),
            .load_data (in_data),
            .out_ready (out_ready[i]),
            .out_valid (valid_vec[i]),
            .out_data  (data_arr[i]),
            .free      (free_vec[i])
`ifdef DEMUX_STATS_EN
            ,
            .out_cnt   (cnt_arr[i])
`endif
        );
    end

    assign out_valid = valid_vec;
    assign out_data0 = data_arr[0];
    assign out_data1 = data_arr[1];
    assign out_data2 = data_arr[2];
    assign out_data3 = data_arr[3];

`ifdef DEMUX_STATS_EN
    assign out_cnt0 = cnt_arr[0];
    assign out_cnt1 = cnt_arr[1];
    assign out_cnt2 = cnt_arr[2];
    assign out_cnt3 = cnt_arr[3];
`endif

endmodule

// File: tb/tb_demux_1_4_stream.sv
// Directed self-checking bench for demux_1_4_stream (WIDTH=4, COUNT_W=8).
// Counter checks are compiled in when DEMUX_STATS_EN is defined.
module tb_demux_1_4_stream;

    localparam int WIDTH   = 4;
    localparam int COUNT_W = 8;

    logic               clk;
    logic               rst;
    logic [WIDTH-1:0]   in_data;
    logic [1:0]         in_sel;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   out_data0, out_data1, out_data2, out_data3;
    logic [3:0]         out_valid;
    logic [3:0]         out_ready;
`ifdef DEMUX_STATS_EN
    logic [COUNT_W-1:0] out_cnt0, out_cnt1, out_cnt2, out_cnt3;
`endif

    int n_checks = 0;
    int n_errors = 0;

    demux_1_4_stream #(
        .WIDTH   (WIDTH),
        .COUNT_W (COUNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data0 (out_data0),
        .out_data1 (out_data1),
        .out_data2 (out_data2),
        .out_data3 (out_data3),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef DEMUX_STATS_EN
        ,
        .out_cnt0  (out_cnt0),
        .out_cnt1  (out_cnt1),
        .out_cnt2  (out_cnt2),
        .out_cnt3  (out_cnt3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] data_of(input int i);
        case (i)
            0:       return out_data0;
            1:       return out_data1;
            2:       return out_data2;
            default: return out_data3;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [WIDTH-1:0] d);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        #1;
    endtask

    // Upstream hold and output stability, sampled on the falling edge.
    logic             prev_stall;
    logic [1:0]       prev_sel;
    logic [WIDTH-1:0] prev_in;
    logic [3:0]       prev_hold;
    logic [WIDTH-1:0] prev_out [4];

    initial begin
        prev_stall = 1'b0;
        prev_hold  = 4'b0;
    end

    always @(negedge clk) begin
        if (prev_stall && !rst)
            chk("upstream_hold", {25'd0, in_valid, in_sel, in_data}, {25'd0, 1'b1, prev_sel, prev_in});
        for (int i = 0; i < 4; i++) begin
            if (prev_hold[i] && !rst)
                chk($sformatf("out_stable%0d", i), 32'(data_of(i)), 32'(prev_out[i]));
            prev_out[i] = data_of(i);
        end
        prev_stall = in_valid && !in_ready && !rst;
        prev_sel   = in_sel;
        prev_in    = in_data;
        prev_hold  = rst ? 4'b0 : (out_valid & ~out_ready);
    end

    logic [WIDTH-1:0] words [4];

    initial begin
        words[0] = 4'hA; words[1] = 4'h5; words[2] = 4'hC; words[3] = 4'h3;
        rst = 1'b1;
        out_ready = 4'b0000;
        drive(1'b0, 2'd0, 4'h0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        step();
        chk("rst_out_data0", 32'(out_data0), 32'd0);
        step();
        rst = 1'b0;

        // Basic routing
        out_ready = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 2'(k), words[k]);
            chk($sformatf("route_rdy%0d", k), 32'(in_ready), 32'd1);
            step();
            chk($sformatf("route_vld%0d", k), 32'(out_valid), 32'(4'b0001 << k));
            chk($sformatf("route_dat%0d", k), 32'(data_of(k)), 32'(words[k]));
        end
        drive(1'b0, 2'd0, 4'h0);
        step();
        chk("route_drained", 32'(out_valid), 32'd0);

        // Stalled output 1 does not block output 2
        out_ready = 4'b1101;
        drive(1'b1, 2'd1, 4'h7);
        chk("stall_rdy7", 32'(in_ready), 32'd1);
        step();
        chk("stall_vld7", 32'(out_valid), 32'b0010);
        drive(1'b1, 2'd2, 4'hE);
        chk("stall_rdyE", 32'(in_ready), 32'd1);
        step();
        chk("stall_vldE", 32'(out_valid), 32'b0110);
        chk("stall_datE", 32'(out_data2), 32'hE);
        drive(1'b1, 2'd1, 4'h9);
        chk("stall_rdy9_blocked", 32'(in_ready), 32'd0);
        step();
        chk("stall_hold7a", 32'(out_data1), 32'h7);
        chk("stall_vld_only1", 32'(out_valid), 32'b0010);
        chk("stall_rdy9_still", 32'(in_ready), 32'd0);
        step();
        chk("stall_hold7b", 32'(out_data1), 32'h7);
        out_ready = 4'b1111;
        #1;
        chk("stall_rdy9_release", 32'(in_ready), 32'd1);
        step();
        chk("stall_dat9", 32'(out_data1), 32'h9);
        chk("stall_vld9", 32'(out_valid), 32'b0010);
        drive(1'b0, 2'd0, 4'h0);
        step();
        chk("stall_drained", 32'(out_valid), 32'd0);

        // Back-to-back on output 3
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 2'd3, 4'(k + 1));
            chk($sformatf("b2b_rdy%0d", k), 32'(in_ready), 32'd1);
            step();
            chk($sformatf("b2b_vld%0d", k), 32'(out_valid), 32'b1000);
            chk($sformatf("b2b_dat%0d", k), 32'(out_data3), 32'(k + 1));
        end
        drive(1'b0, 2'd0, 4'h0);
        step();
        chk("b2b_drained", 32'(out_valid), 32'd0);

        // Concurrency: fill all four, then drain all plus load one
        out_ready = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 2'(k), 4'(k + 1));
            step();
        end
        drive(1'b0, 2'd0, 4'h0);
        chk("conc_full", 32'(out_valid), 32'b1111);
        out_ready = 4'b1111;
        drive(1'b1, 2'd0, 4'h6);
        chk("conc_rdy", 32'(in_ready), 32'd1);
        step();
        chk("conc_vld", 32'(out_valid), 32'b0001);
        chk("conc_dat0", 32'(out_data0), 32'h6);
        drive(1'b0, 2'd0, 4'h0);
        step();

        // Reset mid-stream with slots 1 and 3 full
        out_ready = 4'b0000;
        drive(1'b1, 2'd1, 4'hB);
        step();
        drive(1'b1, 2'd3, 4'hD);
        step();
        drive(1'b1, 2'd2, 4'h4);
        chk("mid_full13", 32'(out_valid), 32'b1010);
        rst = 1'b1;
        #1;
        chk("mid_rst_vld", 32'(out_valid), 32'd0);
        chk("mid_rst_rdy", 32'(in_ready), 32'd0);
        chk("mid_rst_dat1", 32'(out_data1), 32'd0);
        step();
        rst = 1'b0;
        #1;
        chk("mid_release_rdy", 32'(in_ready), 32'd1);
        step();
        chk("mid_release_vld", 32'(out_valid), 32'b0100);
        chk("mid_release_dat2", 32'(out_data2), 32'h4);
        drive(1'b0, 2'd0, 4'h0);

`ifdef DEMUX_STATS_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("cnt_rst", 32'(out_cnt2), 32'd0);
        out_ready = 4'b0100;
        for (int k = 0; k < 257; k++) begin
            drive(1'b1, 2'd2, 4'(k));
            step();
        end
        drive(1'b0, 2'd0, 4'h0);
        step();
        chk("cnt2_wrap", 32'(out_cnt2), 32'd1);
        chk("cnt0", 32'(out_cnt0), 32'd0);
        chk("cnt1", 32'(out_cnt1), 32'd0);
        chk("cnt3", 32'(out_cnt3), 32'd0);
`endif

        step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/demux_1_4_stream.md
Name: demux_1_4_stream

Overview:
- Registered 1-to-4 stream demultiplexer; the inverse of the 4:1 data mux.
- Routes one valid/ready input stream of WIDTH-bit words to one of four output channels, chosen by a per-word 2-bit select.
- Each output channel has a one-entry holding register, so a stalled output does not block traffic to the other outputs.
- Sits between a single producer and four independent consumers in the combinational-logic exercise chain.

Parameters:
WIDTH, 4, data word width in bits; legal range >= 1.
COUNT_W, 8, width of the per-output transfer counters; used only when DEMUX_STATS_EN is defined.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
in_data  input  WIDTH  input word
in_sel  input  2  destination output index for in_data (0..3)
in_valid  input  1  in_data/in_sel are valid
in_ready  output  1  block accepts the word this cycle
out_data0..out_data3  output  WIDTH each  per-output held word
out_valid  output  4  bit i: out_data{i} holds a valid word
out_ready  input  4  bit i: consumer i accepts this cycle
out_cnt0..out_cnt3  output  COUNT_W each  per-output transfer count (DEMUX_STATS_EN only)

Behaviour:
- Reset: asynchronous on rst rising, held while rst=1.
  - out_valid=4'b0000; out_data0..3 = 0; counters = 0.
  - in_ready forced to 0 while rst=1.
- Slot state per output i: {valid_i, data_i}. The slot is free for input when valid_i=0 or out_ready[i]=1.
- in_ready = !rst && (!valid[in_sel] || out_ready[in_sel]), combinational on in_sel and out_ready. This is a deliberate pass-through path.
- Input handshake: in_valid && in_ready. The selected slot loads in_data and sets valid at the next edge. Latency from input handshake to out_valid is exactly 1 cycle.
- Output handshake on i: out_valid[i] && out_ready[i].
  - Drain only: valid_i clears at the next edge; data_i is retained (don't-care).
  - Drain and load on the same slot in the same cycle: data_i takes the new word and valid_i stays 1. This gives full throughput of 1 word/cycle per output.
- Non-selected slots are unaffected by the input, apart from their own drain.
- Stability:
  - out_data{i} must not change while out_valid[i]=1 and out_ready[i]=0.
  - Upstream must hold in_data/in_sel stable while in_valid=1 and in_ready=0. The bench asserts this; the RTL does not check it.
- in_valid=0: in_sel is ignored and no slot loads.
- Different outputs drain independently and concurrently. Up to 4 drains plus 1 load can occur in one cycle.
- Reset mid-operation: all held words are discarded immediately with no handshake. Counters clear.
- No FSM beyond the four slot valid flags. No other state except the counters.

Optional Feature:
- Macro DEMUX_STATS_EN.
- Defined:
  - Ports out_cnt0..out_cnt3 exist.
  - out_cnt{i} increments by 1 at every output handshake on i.
  - Counters wrap from 2^COUNT_W-1 to 0 with no saturation.
  - Counters reset to 0.
- Not defined:
  - Counter ports and logic are absent.
  - All other behaviour is identical.

Decomposition:
- Package demux_pkg:
  - localparam N_OUT = 4.
  - typedef logic [1:0] sel_t.
  - Default WIDTH and COUNT_W constants.
- Sub-module demux_out_slot:
  - Parameterised by WIDTH; one per output, instantiated 4 times.
  - Inputs: clk, rst, load, load_data, out_ready.
  - Outputs: out_valid, out_data, free.
  - Counter also inside the slot, under the same macro.
- Top level responsibilities:
  - Decodes in_sel into a one-hot load vector gated by the input handshake.
  - Muxes the slot free flags to form in_ready.

Test Plan:
1. Reset check: assert rst mid-stream with slots 1 and 3 full -> same cycle out_valid=0000, in_ready=0; after release, in_ready=1 with in_valid=1, in_sel=2.
2. Basic routing: send 4'hA to sel 0, 4'h5 to sel 1, 4'hC to sel 2, 4'h3 to sel 3, all out_ready=1 -> each word appears on its own output exactly 1 cycle after acceptance; other out_valid bits stay 0.
3. Stalled output: out_ready[1]=0, send 4'h7 then 4'h9 to sel 1 -> 4'h7 held stable and in_ready=0 on the second word. Meanwhile 4'hE to sel 2 is accepted. Raise out_ready[1] -> 4'h9 accepted that same cycle, out_data1=9 the next cycle.
4. Back-to-back full throughput: 8 consecutive words to sel 3 with out_ready[3]=1 -> in_ready stays 1, out_valid[3] stays 1 for 8 cycles, data order preserved.
5. Concurrency: all four slots full; in one cycle out_ready=1111 and input 4'h6 to sel 0 -> next cycle out_valid=0001, out_data0=6.
6. DEMUX_STATS_EN with COUNT_W=8: 257 handshakes on output 2 -> out_cnt2=1, other counters = 0.
